// File: rtl/segre_pkg.sv
// segre_pkg: shared types and CSR field constants for the exception controller
package segre_pkg;
  localparam int WORD_SIZE = 32;
  localparam int MSTATUS_MIE_BIT = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
  typedef enum logic [1:0] {IDLE, TRAP_WR, MRET_WR, REDIRECT} exc_state_e;
endpackage

// File: rtl/segre_trap_target.sv
// segre_trap_target: trap PC from mtvec; vectored interrupts only with SEGRE_VECTORED_IRQ_EN
module segre_trap_target
  import segre_pkg::*;
(
  input  logic [WORD_SIZE-1:0] mtvec_i,
`ifdef SEGRE_VECTORED_IRQ_EN
  input  logic [WORD_SIZE-1:0] cause_i,
`endif
  output logic [WORD_SIZE-1:0] target_o
);
  logic [WORD_SIZE-1:0] base;
  assign base = mtvec_i & ~32'h3;
`ifdef SEGRE_VECTORED_IRQ_EN
  assign target_o = (mtvec_i[1:0] == MTVEC_MODE_VECTORED && cause_i[31]) ? base + 32'({cause_i[30:0], 2'b00}) : base;
`else
  assign target_o = base;
`endif
endmodule

// File: rtl/segre_exception_controller.sv
// segre_exception_controller: trap/MRET sequencer writing CSRs and redirecting fetch
// Optional vectored interrupt targets with SEGRE_VECTORED_IRQ_EN.
module segre_exception_controller
  import segre_pkg::*;
#(
  parameter int IRQ_CAUSE = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 exc_valid_i,
  input  logic [WORD_SIZE-1:0] exc_cause_i,
  input  logic [WORD_SIZE-1:0] pc_i,
  input  logic                 irq_i,
  input  logic                 mret_i,
  input  logic [WORD_SIZE-1:0] csr_mstatus_i,
  input  logic [WORD_SIZE-1:0] csr_mtvec_i,
  input  logic [WORD_SIZE-1:0] csr_mepc_i,
  output logic                 exc_we_o,
  output logic [WORD_SIZE-1:0] w_data_mstatus_o,
  output logic [WORD_SIZE-1:0] w_data_mtvec_o,
  output logic [WORD_SIZE-1:0] w_data_mepc_o,
  output logic [WORD_SIZE-1:0] w_data_mcause_o,
  output logic                 flush_o,
  output logic                 busy_o,
  output logic                 redirect_valid_o,
  output logic [WORD_SIZE-1:0] redirect_pc_o,
  input  logic                 redirect_ready_i
);
  localparam logic [WORD_SIZE-1:0] IRQ_MCAUSE = {1'b1, 31'(IRQ_CAUSE)};
  exc_state_e state_q, state_n;
  logic [WORD_SIZE-1:0] pc_q, cause_q, mstatus_q, mtvec_q, mepc_q, target, ms_trap, ms_mret;
  logic mret_q, irq_take, trap_take;
  assign irq_take = irq_i & csr_mstatus_i[MSTATUS_MIE_BIT];
  assign trap_take = exc_valid_i | irq_take;
  segre_trap_target u_target (
    .mtvec_i (mtvec_q),
`ifdef SEGRE_VECTORED_IRQ_EN
    .cause_i (cause_q),
`endif
    .target_o(target)
  );
  always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_n;
  // cause_q only changes on traps, so it is also the last mcause written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= '0;
      cause_q <= '0;
      mstatus_q <= '0;
      mtvec_q <= '0;
      mepc_q <= '0;
      mret_q <= 1'b0;
    end else if (state_q == IDLE && (trap_take || mret_i)) begin
      pc_q <= pc_i;
      mstatus_q <= csr_mstatus_i;
      mtvec_q <= csr_mtvec_i;
      mepc_q <= csr_mepc_i;
      mret_q <= !trap_take;
      if (trap_take) cause_q <= exc_valid_i ? {1'b0, exc_cause_i[30:0]} : IRQ_MCAUSE;
    end
  end
  always_comb begin
    ms_trap = mstatus_q;
    ms_trap[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
    ms_trap[MSTATUS_MIE_BIT] = 1'b0;
    ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    ms_mret = mstatus_q;
    ms_mret[MSTATUS_MIE_BIT] = mstatus_q[MSTATUS_MPIE_BIT];
    ms_mret[MSTATUS_MPIE_BIT] = 1'b1;
    ms_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    state_n = state_q;
    exc_we_o = 1'b0;
    flush_o = 1'b0;
    busy_o = state_q != IDLE;
    redirect_valid_o = 1'b0;
    redirect_pc_o = '0;
    w_data_mstatus_o = '0;
    w_data_mtvec_o = '0;
    w_data_mepc_o = '0;
    w_data_mcause_o = '0;
    case (state_q)
      IDLE: state_n = trap_take ? TRAP_WR : mret_i ? MRET_WR : IDLE;
      TRAP_WR, MRET_WR: begin
        exc_we_o = 1'b1;
        flush_o = 1'b1;
        w_data_mstatus_o = state_q == TRAP_WR ? ms_trap : ms_mret;
        w_data_mtvec_o = mtvec_q;
        w_data_mepc_o = state_q == TRAP_WR ? pc_q : mepc_q;
        w_data_mcause_o = cause_q;
        state_n = REDIRECT;
      end
      default: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o = mret_q ? mepc_q : target;
        state_n = redirect_ready_i ? IDLE : REDIRECT;
      end
    endcase
  end
endmodule
